// File: rtl/boot_slot_select.sv
// ---------------------------------------------------------------------------
// boot_slot_select
//
// Upstream request stage for the ICAP MultiBoot reboot sequencer.
// Debounces the front-panel switches, accepts a host reboot request, latches
// the target slot, computes the SPI flash warm-boot address and presents the
// GENERAL_1 / GENERAL_2 words to the sequencer over a req/ack handshake.
//
// Parameters
//   DB_CYCLES       stable cycles before a synchronised switch vector is taken
//   STARTUP_CYCLES  post-reset lockout during which all triggers are dropped
//
// Ports
//   fastclk     in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   sw[4:1]     in   raw switches; sw[4] reboot button (active-low), sw[3:1] slot
//   host_req    in   one-cycle host reboot request pulse
//   host_slot   in   slot accompanying host_req
//   reboot_ack  in   sequencer has captured the request (level)
//   reboot_req  out  request valid
//   slot        out  latched slot
//   gen1_word   out  warm-boot address [15:0]
//   gen2_word   out  {SPI read opcode, warm-boot address [23:16]}
//   busy        out  high in every state other than IDLE
//   sw_db       out  debounced switch vector
// ---------------------------------------------------------------------------
module boot_slot_select #(
  parameter logic [15:0] DB_CYCLES      = 16'd48000,
  parameter logic [15:0] STARTUP_CYCLES = 16'd64
) (
  input  logic        fastclk,
  input  logic        reset_n,
  input  logic [4:1]  sw,
  input  logic        host_req,
  input  logic [2:0]  host_slot,
  input  logic        reboot_ack,
  output logic        reboot_req,
  output logic [2:0]  slot,
  output logic [15:0] gen1_word,
  output logic [15:0] gen2_word,
  output logic        busy,
  output logic [4:1]  sw_db
);

  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SLOT_W   = 3;
  localparam int unsigned WORD_W   = 16;

  localparam logic [ADDR_W-1:0] SLOT_SIZE = 24'h054000;
  localparam logic [7:0]        SPI_READ  = 8'h03;
  localparam logic [4:1]        SW_IDLE   = 4'b1111;
  localparam logic [CNT_W-1:0]  CNT_MAX   = 16'hFFFF;

  // Reset words correspond to slot 0 (address 0x054000).
  localparam logic [WORD_W-1:0] RST_GEN1 = 16'h4000;
  localparam logic [WORD_W-1:0] RST_GEN2 = 16'h0305;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser on the raw switches
  // -------------------------------------------------------------------------
  logic [4:1] r_sw_meta;
  logic [4:1] r_sw_sync;

  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_meta <= SW_IDLE;
      r_sw_sync <= SW_IDLE;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce: one shared stability counter for the whole vector
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_db_cnt;
  logic             w_db_change;
  logic             w_db_done;

  // Looking one stage ahead clears the counter on the very edge the
  // synchronised value changes, so sw_db follows exactly DB_CYCLES later.
  assign w_db_change = (r_sw_meta != r_sw_sync);
  assign w_db_done   = (r_db_cnt == (DB_CYCLES - 16'd1));

  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt <= '0;
      sw_db    <= SW_IDLE;
    end else begin
      if (w_db_done) begin
        sw_db <= r_sw_sync;
      end
      if (w_db_change || w_db_done) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt != CNT_MAX) begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Button falling-edge detect on the debounced vector
  // -------------------------------------------------------------------------
  logic r_btn_prev;
  logic w_btn_evt;

  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_prev <= 1'b1;
    end else begin
      r_btn_prev <= sw_db[4];
    end
  end

  assign w_btn_evt = r_btn_prev & ~sw_db[4];

  // -------------------------------------------------------------------------
  // Trigger merge: host wins over a simultaneous button event
  // -------------------------------------------------------------------------
  logic              w_trig;
  logic [SLOT_W-1:0] w_trig_slot;

  assign w_trig      = host_req | w_btn_evt;
  assign w_trig_slot = host_req ? host_slot : sw_db[3:1];

  // -------------------------------------------------------------------------
  // Post-reset lockout counter
  // -------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_su_cnt;
  logic             w_su_done;

  // Widened compare keeps STARTUP_CYCLES = 0 from underflowing.
  assign w_su_done = ((17'(r_su_cnt) + 17'd1) >= 17'(STARTUP_CYCLES));

  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_su_cnt <= '0;
    end else if ((r_state == ST_STARTUP) && !w_su_done) begin
      r_su_cnt <= r_su_cnt + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_STARTUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic; triggers outside IDLE are simply not looked at
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STARTUP: if (w_su_done)   w_state_nxt = ST_IDLE;
      ST_IDLE:    if (w_trig)      w_state_nxt = ST_REQ;
      ST_REQ:     if (reboot_ack)  w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (!reboot_ack) w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_STARTUP;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM output logic: next values for the registered outputs
  // -------------------------------------------------------------------------
  logic              w_load;
  logic              w_req_d;
  logic              w_busy_d;
  logic [SLOT_W-1:0] w_slot_d;
  logic [ADDR_W-1:0] w_addr;
  logic [WORD_W-1:0] w_gen1_d;
  logic [WORD_W-1:0] w_gen2_d;

  always_comb begin
    w_load   = 1'b0;
    w_req_d  = 1'b0;
    w_busy_d = 1'b1;
    w_slot_d = slot;
    w_addr   = '0;
    w_gen1_d = gen1_word;
    w_gen2_d = gen2_word;

    w_req_d  = (w_state_nxt == ST_REQ);
    w_busy_d = (w_state_nxt != ST_IDLE);
    w_load   = (r_state == ST_IDLE) && (w_state_nxt == ST_REQ);

    // Slot and words move only on entry to REQ.
    if (w_load) begin
      w_slot_d = w_trig_slot;
      w_addr   = (24'(w_trig_slot) + 24'd1) * SLOT_SIZE;
      w_gen1_d = w_addr[15:0];
      w_gen2_d = {SPI_READ, w_addr[23:16]};
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      reboot_req <= 1'b0;
      busy       <= 1'b1;
      slot       <= '0;
      gen1_word  <= RST_GEN1;
      gen2_word  <= RST_GEN2;
    end else begin
      reboot_req <= w_req_d;
      busy       <= w_busy_d;
      slot       <= w_slot_d;
      gen1_word  <= w_gen1_d;
      gen2_word  <= w_gen2_d;
    end
  end

endmodule

// File: tb/tb_boot_slot_select.sv
// ---------------------------------------------------------------------------
// tb_boot_slot_select
//
// Directed self-checking bench for boot_slot_select with DB_CYCLES = 8 and
// STARTUP_CYCLES = 4. Inputs are driven and outputs sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_boot_slot_select;

  logic        fastclk;
  logic        reset_n;
  logic [4:1]  sw;
  logic        host_req;
  logic [2:0]  host_slot;
  logic        reboot_ack;
  logic        reboot_req;
  logic [2:0]  slot;
  logic [15:0] gen1_word;
  logic [15:0] gen2_word;
  logic        busy;
  logic [4:1]  sw_db;

  int checks   = 0;
  int failures = 0;

  boot_slot_select #(
    .DB_CYCLES      (16'd8),
    .STARTUP_CYCLES (16'd4)
  ) dut (
    .fastclk    (fastclk),
    .reset_n    (reset_n),
    .sw         (sw),
    .host_req   (host_req),
    .host_slot  (host_slot),
    .reboot_ack (reboot_ack),
    .reboot_req (reboot_req),
    .slot       (slot),
    .gen1_word  (gen1_word),
    .gen2_word  (gen2_word),
    .busy       (busy),
    .sw_db      (sw_db)
  );

  initial begin
    fastclk = 1'b0;
    forever #5 fastclk = ~fastclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fastclk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int req_seen;
  int lat;
  int found;

  initial begin
    reset_n    = 1'b0;
    sw         = 4'b1111;
    host_req   = 1'b0;
    host_slot  = 3'd0;
    reboot_ack = 1'b0;
    tickn(3);

    // reset values
    check("rst_req",  32'(reboot_req), 32'd0);
    check("rst_slot", 32'(slot),       32'd0);
    check("rst_gen1", 32'(gen1_word),  32'h4000);
    check("rst_gen2", 32'(gen2_word),  32'h0305);
    check("rst_busy", 32'(busy),       32'd1);
    check("rst_swdb", 32'(sw_db),      32'hF);

    // startup lockout: host pulse on the first edge is dropped
    reset_n = 1'b1;
    host_req = 1'b1; host_slot = 3'd2;
    tick();
    host_req = 1'b0;
    check("su_busy1", 32'(busy), 32'd1);
    check("su_req1",  32'(reboot_req), 32'd0);
    tick(); check("su_busy2", 32'(busy), 32'd1);
    tick(); check("su_busy3", 32'(busy), 32'd1);
    tick(); check("su_busy_end", 32'(busy), 32'd0);
    check("su_req_dropped", 32'(reboot_req), 32'd0);
    check("su_slot_kept", 32'(slot), 32'd0);

    // host request, slot 5 -> 0x1F8000
    host_req = 1'b1; host_slot = 3'd5;
    tick();
    host_req = 1'b0;
    check("host_req",  32'(reboot_req), 32'd1);
    check("host_slot", 32'(slot),       32'd5);
    check("host_gen1", 32'(gen1_word),  32'h8000);
    check("host_gen2", 32'(gen2_word),  32'h031F);
    check("host_busy", 32'(busy),       32'd1);

    // host pulse during REQ is ignored
    host_req = 1'b1; host_slot = 3'd1;
    tick();
    host_req = 1'b0;
    check("req_hold", 32'(reboot_req), 32'd1);
    check("req_slot_stable", 32'(slot), 32'd5);

    // ack releases the request on the next edge
    reboot_ack = 1'b1;
    tick();
    check("ack_req_low", 32'(reboot_req), 32'd0);
    check("ack_busy",    32'(busy),       32'd1);

    // host pulse during RELEASE is ignored
    host_req = 1'b1; host_slot = 3'd2;
    tick();
    host_req = 1'b0;
    check("rel_req_low", 32'(reboot_req), 32'd0);
    check("rel_slot_stable", 32'(slot), 32'd5);
    check("rel_gen2_stable", 32'(gen2_word), 32'h031F);

    // edge sampling ack low returns to IDLE; a trigger on that edge is dropped
    reboot_ack = 1'b0; host_req = 1'b1; host_slot = 3'd6;
    tick();
    host_req = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_drop_req", 32'(reboot_req), 32'd0);
    check("idle_drop_slot", 32'(slot), 32'd5);

    // next edge accepts; ack already high -> REQ lasts one cycle
    reboot_ack = 1'b1; host_req = 1'b1; host_slot = 3'd6;
    tick();
    host_req = 1'b0;
    check("held_req",  32'(reboot_req), 32'd1);
    check("held_slot", 32'(slot),       32'd6);
    check("held_gen1", 32'(gen1_word),  32'hC000);
    check("held_gen2", 32'(gen2_word),  32'h0324);
    tick();
    check("held_req_1cyc", 32'(reboot_req), 32'd0);
    check("held_busy", 32'(busy), 32'd1);
    reboot_ack = 1'b0;
    tick();
    check("held_idle", 32'(busy), 32'd0);

    // switch debounce: settle slot 3 with button released
    sw = 4'b1011;
    tickn(12);
    check("db_settle", 32'(sw_db), 32'hB);
    check("db_no_req", 32'(reboot_req), 32'd0);

    // 3-cycle glitches on the button never pass the debouncer
    req_seen = 0;
    repeat (3) begin
      sw[4] = 1'b0;
      repeat (3) begin tick(); if (reboot_req) req_seen++; end
      sw[4] = 1'b1;
      repeat (3) begin tick(); if (reboot_req) req_seen++; end
    end
    check("glitch_no_req", 32'(req_seen), 32'd0);
    check("glitch_swdb", 32'(sw_db), 32'hB);

    // settled press: 2 sync + 8 debounce + 1 request edges
    sw[4] = 1'b0;
    found = 0; lat = 0;
    for (int i = 1; i <= 30 && found == 0; i++) begin
      tick();
      if (reboot_req) begin found = 1; lat = i; end
    end
    check("sw_req_seen", 32'(found), 32'd1);
    check("sw_latency",  32'(lat),   32'd11);
    check("sw_slot", 32'(slot),      32'd3);
    check("sw_gen1", 32'(gen1_word), 32'h0000);
    check("sw_gen2", 32'(gen2_word), 32'h0315);
    check("sw_swdb", 32'(sw_db),     32'h3);
    reboot_ack = 1'b1; tick();
    reboot_ack = 1'b0; tick();
    check("sw_idle", 32'(busy), 32'd0);

    // simultaneous button event and host request: host wins, one request
    sw[4] = 1'b1;
    tickn(14);
    check("sim_release", 32'(sw_db), 32'hB);
    sw[4] = 1'b0;
    tickn(10);
    check("sim_db_fall", 32'(sw_db), 32'h3);
    check("sim_pre_req", 32'(reboot_req), 32'd0);
    host_req = 1'b1; host_slot = 3'd7;
    tick();
    host_req = 1'b0;
    check("sim_req",  32'(reboot_req), 32'd1);
    check("sim_slot", 32'(slot),       32'd7);
    check("sim_gen1", 32'(gen1_word),  32'h0000);
    check("sim_gen2", 32'(gen2_word),  32'h032A);
    reboot_ack = 1'b1; tick();
    reboot_ack = 1'b0; tick();
    req_seen = 0;
    repeat (20) begin tick(); if (reboot_req) req_seen++; end
    check("sim_single_req", 32'(req_seen), 32'd0);

    // mid-request reset drops reboot_req without a clock edge
    sw = 4'b1111;
    host_req = 1'b1; host_slot = 3'd1;
    tick();
    host_req = 1'b0;
    check("mr_req",  32'(reboot_req), 32'd1);
    check("mr_gen2", 32'(gen2_word),  32'h030A);
    #3;
    reset_n = 1'b0;
    #1;
    check("mr_req_async", 32'(reboot_req), 32'd0);
    check("mr_busy",      32'(busy),       32'd1);
    check("mr_slot",      32'(slot),       32'd0);
    check("mr_gen1",      32'(gen1_word),  32'h4000);
    #2;
    reset_n = 1'b1;
    tick(); check("mr_busy1", 32'(busy), 32'd1);
    tick(); check("mr_busy2", 32'(busy), 32'd1);
    tick(); check("mr_busy3", 32'(busy), 32'd1);
    tick(); check("mr_busy_end", 32'(busy), 32'd0);
    check("mr_req_end", 32'(reboot_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
